hb_target: RTL and testbench
============================

HB_TARGET -- requirements
Module: hb_target

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning memory depth of 2^ADDR_W 16-bit words.
REQ-002 SHALL have parameter LATENCY, default 6, meaning initial-access latency in hb_ck rising edges.
REQ-003 SHALL have parameter FIXED_2X, default 1, meaning that latency is always doubled and RWDS is driven high during the CA phase.
REQ-004 SHALL have parameter CR0_RST, default 16'h8F1F, meaning the CR0 reset value.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port hb_cs_l, input, 1 bit: bus chip select, active low.
REQ-008 SHALL have port hb_ck, input, 1 bit: bus clock, oversampled by clk.
REQ-009 SHALL have port hb_rst_l, input, 1 bit: bus reset, active low.
REQ-010 SHALL have port hb_dq_in, input, 8 bits: DQ sampled value.
REQ-011 SHALL have ports hb_dq_out (output, 8 bits) and hb_dq_oe (output, 1 bit): DQ drive value and drive enable.
REQ-012 SHALL have port hb_rwds_in, input, 1 bit: RWDS sampled value (write mask).
REQ-013 SHALL have ports hb_rwds_out (output, 1 bit) and hb_rwds_oe (output, 1 bit): RWDS drive value and drive enable.
REQ-014 SHALL have port txn_done, output, 1 bit: one-clk pulse at the end of any transaction.

Function
REQ-015 SHALL register hb_ck, hb_cs_l, hb_dq_in and hb_rwds_in once; edges are detected from the registered hb_ck against its previous value; hb_ck SHALL toggle at most once per 2 clk cycles.
REQ-016 SHALL move one bus byte per hb_ck edge, rise then fall; each 16-bit word is big-endian, with the rising-edge byte as [15:8].
REQ-017 SHALL implement the states IDLE, CA, LAT, WDATA, RDATA and REGWR.
  - IDLE -> CA on a registered hb_cs_l falling edge.
REQ-018 SHALL in CA shift in 6 bytes as CA[47:0], MSB first.
  - CA[47]: 1 = read.
  - CA[46]: 1 = register space.
  - Word address = {CA[44:16], CA[2:0]} truncated to ADDR_W bits.
REQ-019 SHALL in CA drive hb_rwds_oe=1 with hb_rwds_out=FIXED_2X.
REQ-020 SHALL after the 6th CA byte branch as follows:
  - Register write -> REGWR.
  - Anything else -> LAT, counting L = LATENCY*(FIXED_2X?2:1) hb_ck rising edges; the data phase starts on the next rising edge.
REQ-021 SHALL in WDATA write each completed word to mem[addr], then increment addr.
  - A byte whose sampled RWDS is 1 SHALL be masked (not written).
  - hb_dq_oe and hb_rwds_oe SHALL be 0.
REQ-022 SHALL in RDATA drive hb_dq_oe=1 and hb_rwds_oe=1.
  - Present mem[addr][15:8] with hb_rwds_out=1 within 1 clk after each rising edge.
  - Present [7:0] with hb_rwds_out=0 within 1 clk after each falling edge, then increment addr.
  - Memory reads SHALL be prefetched so there are no wait states.
REQ-023 SHALL apply linear bursts with addr wrapping from 2^ADDR_W-1 to 0.
REQ-024 SHALL in a register-space read return CR0 for every word.
REQ-025 SHALL in REGWR load the next full word into CR0 with zero latency, then ignore further bytes.
REQ-026 SHALL on hb_cs_l going high in any state:
  - Go to IDLE.
  - Drop both OEs within 1 clk.
  - Discard any half-completed write word.
  - Pulse txn_done for 1 clk.
REQ-027 SHALL treat registered hb_cs_l rising and falling in the same sample as a normal deassert.
  - A hb_cs_l falling edge SHALL restart CA from byte 0.

Reset
REQ-028 SHALL on reset high asynchronously set the following, with no memory clearing:
  - state=IDLE.
  - hb_dq_oe=0, hb_rwds_oe=0, hb_dq_out=0, hb_rwds_out=0.
  - txn_done=0.
  - CR0=CR0_RST.
  - Byte and latency counters cleared.
REQ-029 SHALL treat hb_rst_l=0 as a synchronous equivalent of REQ-028, applied on the next clk.
REQ-030 SHALL on reset mid-burst release the bus in the same cycle (combinational path from reset to the OEs via async-clear flops).

Configuration
REQ-031 SHALL use macro HB_TARGET_REGWR_EN to compile register writes in or out.
  - Defined: REGWR per REQ-025.
  - Undefined: REGWR is not built; a register write idles in LAT/WDATA with writes suppressed, and CR0 stays at CR0_RST.

Verification
REQ-032 SHALL cover a write of 2 words 16'hA55A, 16'h1234 at word 0x10 followed by a read of 2 words at 0x10 -> DQ returns A5,5A,12,34 with RWDS 1,0,1,0; txn_done pulses twice.
REQ-033 SHALL cover a write at 0x20 of 16'hFFFF then 16'h00CC with RWDS=1 on the first byte -> a read returns 16'hFFCC.
REQ-034 SHALL cover a 3-word read at 0xFF with ADDR_W=8 -> returns mem[0xFF], mem[0x00], mem[0x01].
REQ-035 SHALL cover a read with LATENCY=6 and FIXED_2X=1 -> the first data byte is driven after exactly 12 post-CA hb_ck rising edges, with RWDS=1 throughout CA.
REQ-036 SHALL cover deasserting hb_cs_l after the first byte of a write word at 0x30 -> mem[0x30] is unchanged, OEs are 0 within 1 clk, and state=IDLE.
REQ-037 SHALL cover a register write of 16'h8F17 with HB_TARGET_REGWR_EN defined, then a register read -> 16'h8F17 with the macro defined, and 16'h8F1F with it undefined.

Source files
------------

// File: rtl/hb_target.sv
// hb_target: HyperBus-style memory target. hb_ck is oversampled by clk. The array is 2^ADDR_W x 16 bits.
// Define HB_TARGET_REGWR_EN to build CR0 register writes; without it, CR0 is fixed at CR0_RST.
module hb_target #(
  parameter int          ADDR_W   = 8,
  parameter int          LATENCY  = 6,
  parameter int          FIXED_2X = 1,
  parameter logic [15:0] CR0_RST  = 16'h8F1F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hb_cs_l,
  input  logic       hb_ck,
  input  logic       hb_rst_l,
  input  logic [7:0] hb_dq_in,
  output logic [7:0] hb_dq_out,
  output logic       hb_dq_oe,
  input  logic       hb_rwds_in,
  output logic       hb_rwds_out,
  output logic       hb_rwds_oe,
  output logic       txn_done
);

  localparam int         LAT_CYC  = LATENCY * ((FIXED_2X != 0) ? 2 : 1);
  localparam logic [7:0] LAT_LAST = 8'(LAT_CYC - 1);
  localparam logic       RWDS_CA  = (FIXED_2X != 0);

  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA, REGWR} state_t;

  logic        ck_reg, ck_prev_reg, cs_reg, cs_prev_reg, rwds_in_reg;
  logic [7:0]  dq_in_reg;
  logic        ck_rise, ck_fall;

  state_t              state_reg;
  logic [2:0]          byte_cnt_reg;
  logic [7:0]          lat_cnt_reg;
  logic [39:0]         ca_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                read_reg, space_reg, half_reg, mask_hi_reg;
  logic [7:0]          wr_hi_reg;
  logic [15:0]         cr0_reg;
  logic [7:0]          dq_out_reg;
  logic                dq_oe_reg, rwds_out_reg, rwds_oe_reg, txn_done_reg;
`ifdef HB_TARGET_REGWR_EN
  logic                reg_done_reg;
`endif

  logic [47:0] ca_next;
  logic [31:0] ca_addr;
  logic [15:0] rd_data;
  logic        wr_fire;
  logic        unused_ca;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  logic [15:0] rd_word_reg;

  // Bus inputs are registered exactly once; edges come from the registered hb_ck.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ck_reg      <= 1'b0;
      ck_prev_reg <= 1'b0;
      cs_reg      <= 1'b1;
      cs_prev_reg <= 1'b1;
      dq_in_reg   <= 8'h00;
      rwds_in_reg <= 1'b0;
    end else begin
      ck_reg      <= hb_ck;
      ck_prev_reg <= ck_reg;
      cs_reg      <= hb_cs_l;
      cs_prev_reg <= cs_reg;
      dq_in_reg   <= hb_dq_in;
      rwds_in_reg <= hb_rwds_in;
    end
  end

  assign ck_rise   = ck_reg & ~ck_prev_reg;
  assign ck_fall   = ~ck_reg & ck_prev_reg;
  assign ca_next   = {ca_reg, dq_in_reg};
  assign ca_addr   = {ca_next[44:16], ca_next[2:0]};
  assign unused_ca = ^{ca_next, ca_addr};
  assign rd_data   = space_reg ? cr0_reg : rd_word_reg;
  assign wr_fire   = (state_reg == WDATA) && ck_fall && half_reg && !cs_reg && hb_rst_l && !space_reg;

  // rd_word_reg tracks mem[addr_reg] every clk, so the next word is always ready before its rising edge.
  always_ff @(posedge clk) begin
    if (wr_fire && !mask_hi_reg) mem[addr_reg][15:8] <= wr_hi_reg;
    if (wr_fire && !rwds_in_reg) mem[addr_reg][7:0]  <= dq_in_reg;
    rd_word_reg <= mem[addr_reg];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= 3'd0;
      lat_cnt_reg  <= 8'd0;
      ca_reg       <= 40'd0;
      addr_reg     <= '0;
      read_reg     <= 1'b0;
      space_reg    <= 1'b0;
      half_reg     <= 1'b0;
      mask_hi_reg  <= 1'b0;
      wr_hi_reg    <= 8'h00;
      cr0_reg      <= CR0_RST;
      dq_out_reg   <= 8'h00;
      dq_oe_reg    <= 1'b0;
      rwds_out_reg <= 1'b0;
      rwds_oe_reg  <= 1'b0;
      txn_done_reg <= 1'b0;
`ifdef HB_TARGET_REGWR_EN
      reg_done_reg <= 1'b0;
`endif
    end else if (!hb_rst_l) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= 3'd0;
      lat_cnt_reg  <= 8'd0;
      ca_reg       <= 40'd0;
      addr_reg     <= '0;
      read_reg     <= 1'b0;
      space_reg    <= 1'b0;
      half_reg     <= 1'b0;
      mask_hi_reg  <= 1'b0;
      wr_hi_reg    <= 8'h00;
      cr0_reg      <= CR0_RST;
      dq_out_reg   <= 8'h00;
      dq_oe_reg    <= 1'b0;
      rwds_out_reg <= 1'b0;
      rwds_oe_reg  <= 1'b0;
      txn_done_reg <= 1'b0;
`ifdef HB_TARGET_REGWR_EN
      reg_done_reg <= 1'b0;
`endif
    end else begin
      txn_done_reg <= 1'b0;
      if (cs_reg) begin
        // Deselect wins over everything, including a same-sample reselect.
        if (!cs_prev_reg) txn_done_reg <= 1'b1;
        state_reg    <= IDLE;
        byte_cnt_reg <= 3'd0;
        lat_cnt_reg  <= 8'd0;
        half_reg     <= 1'b0;
        dq_oe_reg    <= 1'b0;
        rwds_oe_reg  <= 1'b0;
      end else if (cs_prev_reg) begin
        state_reg    <= CA;
        byte_cnt_reg <= 3'd0;
        lat_cnt_reg  <= 8'd0;
        half_reg     <= 1'b0;
        dq_oe_reg    <= 1'b0;
        rwds_oe_reg  <= 1'b1;
        rwds_out_reg <= RWDS_CA;
      end else begin
        case (state_reg)
          CA: begin
            if (ck_rise || ck_fall) begin
              ca_reg       <= ca_next[39:0];
              byte_cnt_reg <= byte_cnt_reg + 3'd1;
              if (byte_cnt_reg == 3'd5) begin
                rwds_oe_reg  <= 1'b0;
                rwds_out_reg <= 1'b0;
                addr_reg     <= ca_addr[ADDR_W-1:0];
                read_reg     <= ca_next[47];
                space_reg    <= ca_next[46];
                lat_cnt_reg  <= 8'd0;
                half_reg     <= 1'b0;
`ifdef HB_TARGET_REGWR_EN
                reg_done_reg <= 1'b0;
                state_reg    <= (!ca_next[47] && ca_next[46]) ? REGWR : LAT;
`else
                state_reg    <= LAT;
`endif
              end
            end
          end
          LAT: begin
            if (ck_rise) begin
              if (lat_cnt_reg == LAT_LAST) state_reg <= read_reg ? RDATA : WDATA;
              else lat_cnt_reg <= lat_cnt_reg + 8'd1;
            end
          end
          WDATA: begin
            if (ck_rise) begin
              wr_hi_reg   <= dq_in_reg;
              mask_hi_reg <= rwds_in_reg;
              half_reg    <= 1'b1;
            end else if (ck_fall && half_reg) begin
              half_reg <= 1'b0;
              addr_reg <= addr_reg + ADDR_W'(1);
            end
          end
          RDATA: begin
            // The falling edge left over from the final latency rise is skipped via dq_oe_reg.
            if (ck_rise) begin
              dq_oe_reg    <= 1'b1;
              rwds_oe_reg  <= 1'b1;
              dq_out_reg   <= rd_data[15:8];
              rwds_out_reg <= 1'b1;
            end else if (ck_fall && dq_oe_reg) begin
              dq_out_reg   <= rd_data[7:0];
              rwds_out_reg <= 1'b0;
              addr_reg     <= addr_reg + ADDR_W'(1);
            end
          end
`ifdef HB_TARGET_REGWR_EN
          REGWR: begin
            if (!reg_done_reg) begin
              if (ck_rise) begin
                wr_hi_reg <= dq_in_reg;
                half_reg  <= 1'b1;
              end else if (ck_fall && half_reg) begin
                cr0_reg      <= {wr_hi_reg, dq_in_reg};
                half_reg     <= 1'b0;
                reg_done_reg <= 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Gating with the registered select releases the bus one clk after hb_cs_l rises.
  assign hb_dq_oe    = dq_oe_reg & ~cs_reg;
  assign hb_rwds_oe  = rwds_oe_reg & ~cs_reg;
  assign hb_dq_out   = dq_out_reg;
  assign hb_rwds_out = rwds_out_reg;
  assign txn_done    = txn_done_reg;

endmodule

// File: tb/tb_hb_target.sv
// Self-checking bench for hb_target: a directed vector table, randomized write/read bursts against a word-array model, and reset corner cases.
module tb_hb_target;

  localparam int LAT_RISES = 12;

`ifdef HB_TARGET_REGWR_EN
  localparam bit REGWR_EN = 1'b1;
`else
  localparam bit REGWR_EN = 1'b0;
`endif
  localparam logic [15:0] REG_EXP = REGWR_EN ? 16'h8F17 : 16'h8F1F;

  typedef struct packed {
    logic             rd;
    logic             rs;
    logic [7:0]       addr;
    logic [1:0]       n;
    logic [2:0][15:0] w;
    logic [5:0]       msk;
    logic             abort;
    logic [2:0][15:0] e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hb_cs_l = 1'b1;
  logic       hb_ck = 1'b0;
  logic       hb_rst_l = 1'b1;
  logic [7:0] hb_dq_in = 8'h00;
  logic       hb_rwds_in = 1'b0;
  logic [7:0] hb_dq_out;
  logic       hb_dq_oe, hb_rwds_out, hb_rwds_oe, txn_done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [15:0] model_mem [256];
  logic [15:0] model_cr0 = 16'h8F1F;
  vec_t        tbl [13];

  hb_target dut (
    .clk(clk), .reset(reset), .hb_cs_l(hb_cs_l), .hb_ck(hb_ck), .hb_rst_l(hb_rst_l),
    .hb_dq_in(hb_dq_in), .hb_dq_out(hb_dq_out), .hb_dq_oe(hb_dq_oe),
    .hb_rwds_in(hb_rwds_in), .hb_rwds_out(hb_rwds_out), .hb_rwds_oe(hb_rwds_oe),
    .txn_done(txn_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (txn_done === 1'b1) done_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rd, logic rs, logic [7:0] addr, logic [1:0] n,
                              logic [15:0] w0, logic [15:0] w1, logic [15:0] w2,
                              logic [5:0] msk, logic abort,
                              logic [15:0] e0, logic [15:0] e1, logic [15:0] e2);
    vec_t v;
    v.rd = rd; v.rs = rs; v.addr = addr; v.n = n;
    v.w = {w2, w1, w0}; v.msk = msk; v.abort = abort; v.e = {e2, e1, e0};
    return v;
  endfunction

  // One bus byte: data set up one clk ahead of the hb_ck toggle, then 3 clks for the response.
  task automatic edge_(input logic [7:0] d, input logic rw);
    @(negedge clk); hb_dq_in = d; hb_rwds_in = rw;
    @(negedge clk); hb_ck = ~hb_ck;
    repeat (3) @(negedge clk);
  endtask

  task automatic begin_txn(input logic rd, input logic rs, input logic [7:0] addr, input string tag);
    logic [47:0] ca;
    logic [31:0] wa;
    logic        ok;
    wa = {24'd0, addr};
    ca = {rd, rs, 1'b0, wa[31:3], 13'd0, wa[2:0]};
    @(negedge clk); hb_cs_l = 1'b0;
    repeat (2) @(negedge clk);
    ok = (hb_rwds_oe === 1'b1) && (hb_rwds_out === 1'b1);
    for (int i = 0; i < 6; i++) begin
      edge_(ca[47-8*i -: 8], 1'b0);
      if (i < 5) ok = ok && (hb_rwds_oe === 1'b1) && (hb_rwds_out === 1'b1) && (hb_dq_oe === 1'b0);
    end
    chk({tag, " ca_rwds"}, 32'(ok), 32'd1);
    if (!(rs && !rd && REGWR_EN)) begin
      ok = 1'b1;
      for (int i = 0; i < 2 * LAT_RISES; i++) begin
        edge_(8'h00, 1'b0);
        ok = ok && (hb_dq_oe === 1'b0) && (hb_rwds_oe === 1'b0);
      end
      chk({tag, " lat_quiet"}, 32'(ok), 32'd1);
    end
  endtask

  task automatic end_txn(input string tag);
    @(negedge clk); hb_cs_l = 1'b1;
    @(negedge clk);
    chk({tag, " oe_release"}, {30'd0, hb_dq_oe, hb_rwds_oe}, 32'd0);
    if (hb_ck) begin
      @(negedge clk); hb_ck = 1'b0;
    end
    repeat (4) @(negedge clk);
    exp_done++;
    chk({tag, " txn_done"}, done_cnt, exp_done);
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    begin_txn(v.rd, v.rs, v.addr, tag);
    for (int k = 0; k < int'(v.n); k++) begin
      if (v.rd) begin
        edge_(8'h00, 1'b0);
        chk($sformatf("%s w%0d hi", tag, k), {21'd0, hb_dq_oe, hb_rwds_oe, hb_rwds_out, hb_dq_out},
            {21'd0, 1'b1, 1'b1, 1'b1, v.e[k][15:8]});
        edge_(8'h00, 1'b0);
        chk($sformatf("%s w%0d lo", tag, k), {21'd0, hb_dq_oe, hb_rwds_oe, hb_rwds_out, hb_dq_out},
            {21'd0, 1'b1, 1'b1, 1'b0, v.e[k][7:0]});
      end else begin
        edge_(v.w[k][15:8], v.msk[2*k+1]);
        if (v.abort) break;
        edge_(v.w[k][7:0], v.msk[2*k]);
      end
    end
    end_txn(tag);
    $display("txn %s: %s %s addr=%02h words=%0d%s", tag, v.rd ? "read" : "write",
             v.rs ? "reg" : "mem", v.addr, v.n, v.abort ? " (aborted)" : "");
  endtask

  task automatic model_apply(input vec_t v);
    logic [7:0] a;
    if (v.rd) return;
    if (v.rs) begin
      if (REGWR_EN && !v.abort) model_cr0 = v.w[0];
      return;
    end
    for (int k = 0; k < int'(v.n); k++) begin
      if (v.abort) break;
      a = v.addr + 8'(k);
      if (!v.msk[2*k+1]) model_mem[a][15:8] = v.w[k][15:8];
      if (!v.msk[2*k])   model_mem[a][7:0]  = v.w[k][7:0];
    end
  endtask

  initial begin
    vec_t       v;
    logic [7:0] a;
    logic [1:0] n;

    tbl[0]  = mk(1, 1, 8'h00, 2'd1, 16'h0, 16'h0, 16'h0, 6'h00, 0, 16'h8F1F, 16'h0, 16'h0);
    tbl[1]  = mk(0, 0, 8'h10, 2'd2, 16'hA55A, 16'h1234, 16'h0, 6'h00, 0, 16'h0, 16'h0, 16'h0);
    tbl[2]  = mk(1, 0, 8'h10, 2'd2, 16'h0, 16'h0, 16'h0, 6'h00, 0, 16'hA55A, 16'h1234, 16'h0);
    tbl[3]  = mk(0, 0, 8'h20, 2'd1, 16'hFFFF, 16'h0, 16'h0, 6'h00, 0, 16'h0, 16'h0, 16'h0);
    tbl[4]  = mk(0, 0, 8'h20, 2'd1, 16'h00CC, 16'h0, 16'h0, 6'h02, 0, 16'h0, 16'h0, 16'h0);
    tbl[5]  = mk(1, 0, 8'h20, 2'd1, 16'h0, 16'h0, 16'h0, 6'h00, 0, 16'hFFCC, 16'h0, 16'h0);
    tbl[6]  = mk(0, 0, 8'hFF, 2'd3, 16'h1111, 16'h2222, 16'h3333, 6'h00, 0, 16'h0, 16'h0, 16'h0);
    tbl[7]  = mk(1, 0, 8'hFF, 2'd3, 16'h0, 16'h0, 16'h0, 6'h00, 0, 16'h1111, 16'h2222, 16'h3333);
    tbl[8]  = mk(0, 0, 8'h30, 2'd1, 16'h5A5A, 16'h0, 16'h0, 6'h00, 0, 16'h0, 16'h0, 16'h0);
    tbl[9]  = mk(0, 0, 8'h30, 2'd1, 16'hBEEF, 16'h0, 16'h0, 6'h00, 1, 16'h0, 16'h0, 16'h0);
    tbl[10] = mk(1, 0, 8'h30, 2'd1, 16'h0, 16'h0, 16'h0, 6'h00, 0, 16'h5A5A, 16'h0, 16'h0);
    tbl[11] = mk(0, 1, 8'h00, 2'd1, 16'h8F17, 16'h0, 16'h0, 6'h00, 0, 16'h0, 16'h0, 16'h0);
    tbl[12] = mk(1, 1, 8'h00, 2'd2, 16'h0, 16'h0, 16'h0, 6'h00, 0, REG_EXP, REG_EXP, 16'h0);

    repeat (3) @(negedge clk);
    chk("reset outputs", {20'd0, hb_dq_oe, hb_rwds_oe, hb_rwds_out, txn_done, hb_dq_out}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle outputs", {20'd0, hb_dq_oe, hb_rwds_oe, hb_rwds_out, txn_done, hb_dq_out}, 32'd0);
    chk("idle txn_done", done_cnt, 0);

    for (int i = 0; i < 13; i++) begin
      do_txn(tbl[i], $sformatf("v%0d", i));
      model_apply(tbl[i]);
    end

    for (int r = 0; r < 5; r++) begin
      a = 8'($urandom_range(0, 255));
      n = 2'($urandom_range(1, 3));
      v = mk(0, 0, a, n, 16'($urandom), 16'($urandom), 16'($urandom), 6'h00, 0, 16'h0, 16'h0, 16'h0);
      do_txn(v, $sformatf("r%0d_fill", r));
      model_apply(v);
      v = mk(0, 0, a, n, 16'($urandom), 16'($urandom), 16'($urandom),
             6'($urandom_range(0, 63)), 0, 16'h0, 16'h0, 16'h0);
      do_txn(v, $sformatf("r%0d_mask", r));
      model_apply(v);
      v = mk(1, 0, a, n, 16'h0, 16'h0, 16'h0, 6'h00, 0,
             model_mem[a], model_mem[a + 8'd1], model_mem[a + 8'd2]);
      do_txn(v, $sformatf("r%0d_read", r));
    end

    // Bus reset mid-burst: OEs drop at the next clk, and deselect still ends the transaction.
    begin_txn(1'b1, 1'b0, 8'h10, "busrst");
    edge_(8'h00, 1'b0);
    chk("busrst driving", {31'd0, hb_dq_oe}, 32'd1);
    @(negedge clk); hb_rst_l = 1'b0;
    @(negedge clk);
    chk("busrst release", {30'd0, hb_dq_oe, hb_rwds_oe}, 32'd0);
    hb_rst_l = 1'b1;
    end_txn("busrst");
    $display("txn busrst: read mem addr=10 cut by hb_rst_l");

    // Async reset mid-burst: the bus is released with no clk edge in between.
    begin_txn(1'b1, 1'b0, 8'h20, "arst");
    edge_(8'h00, 1'b0);
    chk("arst driving", {31'd0, hb_dq_oe}, 32'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("arst release", {20'd0, hb_dq_oe, hb_rwds_oe, hb_rwds_out, txn_done, hb_dq_out}, 32'd0);
    hb_cs_l = 1'b1;
    hb_ck = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst txn_done", done_cnt, exp_done);
    $display("txn arst: read mem addr=20 cut by reset");
    model_cr0 = 16'h8F1F;
    v = mk(1, 1, 8'h00, 2'd1, 16'h0, 16'h0, 16'h0, 6'h00, 0, model_cr0, 16'h0, 16'h0);
    do_txn(v, "cr0_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
